// File: rtl/fpu_pkg.sv
// Shared constants, FSM state type and operand classes for the packed binary32 multiplier.
package fpu_pkg;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int LANES    = 2;
  localparam logic [31:0] QNAN    = 32'h7fc00000;
  localparam logic [31:0] POS_INF = 32'h7f800000;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_PACK, S_DONE} state_t;
  typedef enum logic [1:0] {CLS_ZERO, CLS_NORMAL, CLS_INF, CLS_NAN} fp_class_t;

  // Class of a product from the classes of its operands; Inf*0 is invalid.
  function automatic fp_class_t mul_class(input fp_class_t a, input fp_class_t b);
    if (a == CLS_NAN || b == CLS_NAN) return CLS_NAN;
    if ((a == CLS_INF && b == CLS_ZERO) || (a == CLS_ZERO && b == CLS_INF)) return CLS_NAN;
    if (a == CLS_INF || b == CLS_INF) return CLS_INF;
    if (a == CLS_ZERO || b == CLS_ZERO) return CLS_ZERO;
    return CLS_NORMAL;
  endfunction
endpackage

// File: rtl/fp32_unpack.sv
// Combinational binary32 field split with flush-to-zero of denormals.
module fp32_unpack
  import fpu_pkg::*;
(
  input  logic [31:0]         val,
  output logic                sign,
  output logic [EXP_W-1:0]    exp,
  output logic [FRAC_W:0]     mant,
  output fp_class_t           cls
);
  always_comb begin
    sign = val[31];
    exp  = val[30:23];
    mant = {1'b1, val[FRAC_W-1:0]};
    cls  = CLS_NORMAL;
    if (exp == '0) begin
      cls  = CLS_ZERO;
      mant = '0;
    end else if (exp == '1) begin
      cls = (val[FRAC_W-1:0] != '0) ? CLS_NAN : CLS_INF;
    end
  end
endmodule

// File: rtl/fpu_mul_seq.sv
// Multicycle packed 2x binary32 multiplier sharing one 24x24 mantissa multiplier.
// FPU_MUL_RNE_EN selects round-to-nearest-even; otherwise results are truncated.
module fpu_mul_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [2:0]  flags
);
  // Handshake: start is accepted only in IDLE (busy=0); done pulses once per
  // accepted start with result/flags valid; start while busy is dropped.
`ifdef FPU_MUL_RNE_EN
  localparam int PW = 48;
`else
  localparam int PW = 25;
`endif

  state_t state, state_n;
  logic [63:0] a_r, b_r;
  logic        lane;
  logic        sign_r;
  logic signed [9:0] exp_r;
  logic [PW-1:0] prod_r;
  fp_class_t   cls_r;
  logic [23:0] mant_r;
  logic [2:0]  flags_acc;
`ifdef FPU_MUL_RNE_EN
  logic guard_r, sticky_r;
`endif

  logic sa, sb;
  logic [7:0] ea, eb;
  logic [23:0] ma, mb;
  fp_class_t ca, cb;

  fp32_unpack u_unpack_a (.val(lane ? a_r[63:32] : a_r[31:0]), .sign(sa), .exp(ea), .mant(ma), .cls(ca));
  fp32_unpack u_unpack_b (.val(lane ? b_r[63:32] : b_r[31:0]), .sign(sb), .exp(eb), .mant(mb), .cls(cb));

  logic signed [9:0] exp_sum;
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

  // Normalisation of the registered product (bit PW-1 is product bit 47).
  logic [23:0] norm_mant;
  logic signed [9:0] norm_exp;
  always_comb begin
    norm_mant = prod_r[PW-1] ? prod_r[PW-1 -: 24] : prod_r[PW-2 -: 24];
    norm_exp  = prod_r[PW-1] ? exp_r + 10'sd1 : exp_r;
  end

  // Rounding, carry-out and range checks for the current lane.
  logic        round_up;
  logic [24:0] mant_rnd;
  logic signed [9:0] exp_rnd;
  logic [22:0] frac_rnd;
  logic [31:0] lane_res;
  logic [2:0]  lane_flags;
  always_comb begin
`ifdef FPU_MUL_RNE_EN
    round_up = guard_r & (sticky_r | mant_r[0]);
`else
    round_up = 1'b0;
`endif
    mant_rnd   = {1'b0, mant_r} + {24'd0, round_up};
    exp_rnd    = mant_rnd[24] ? exp_r + 10'sd1 : exp_r;
    frac_rnd   = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
    lane_res   = {sign_r, 31'd0};
    lane_flags = 3'b000;
    case (cls_r)
      CLS_NAN: begin
        lane_res   = QNAN;
        lane_flags = 3'b100;
      end
      CLS_INF:  lane_res = POS_INF | {sign_r, 31'd0};
      CLS_ZERO: lane_res = {sign_r, 31'd0};
      default: begin
        if (exp_rnd >= 10'sd255) begin
          lane_res   = POS_INF | {sign_r, 31'd0};
          lane_flags = 3'b010;
        end else if (exp_rnd <= 10'sd0) begin
          lane_res   = {sign_r, 31'd0};
          lane_flags = 3'b001;
        end else begin
          lane_res = {sign_r, exp_rnd[7:0], frac_rnd};
        end
      end
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_MUL;
      S_MUL:  state_n = S_NORM;
      S_NORM: state_n = S_PACK;
      S_PACK: state_n = lane ? S_DONE : S_MUL;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r       <= '0;
      b_r       <= '0;
      lane      <= 1'b0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      prod_r    <= '0;
      cls_r     <= CLS_ZERO;
      mant_r    <= '0;
      flags_acc <= '0;
      result    <= '0;
      flags     <= '0;
`ifdef FPU_MUL_RNE_EN
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_r       <= op_a;
          b_r       <= op_b;
          lane      <= 1'b0;
          flags_acc <= '0;
        end
        S_MUL: begin
          sign_r <= sa ^ sb;
          exp_r  <= exp_sum;
          prod_r <= PW'((48'(ma) * 48'(mb)) >> (48 - PW));
          cls_r  <= mul_class(ca, cb);
        end
        S_NORM: begin
          mant_r <= norm_mant;
          exp_r  <= norm_exp;
`ifdef FPU_MUL_RNE_EN
          guard_r  <= prod_r[47] ? prod_r[23] : prod_r[22];
          sticky_r <= prod_r[47] ? (|prod_r[22:0]) : (|prod_r[21:0]);
`endif
        end
        S_PACK: begin
          if (!lane) begin
            result[31:0] <= lane_res;
            flags_acc    <= flags_acc | lane_flags;
            lane         <= 1'b1;
          end else begin
            result[63:32] <= lane_res;
            flags         <= flags_acc | lane_flags;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_mul_seq.sv
// Directed scoreboard bench for fpu_mul_seq: stimulus pushes expectations, a monitor checks each done.
module tb_fpu_mul_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] op_a, op_b;
  logic        busy, done;
  logic [63:0] result;
  logic [2:0]  flags;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [66:0] exp_q[$];
  int          cyc_q[$];
  logic [66:0] mon_e;
  int          mon_c;

  fpu_mul_seq dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 result=%h expected no done", result);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        check("result", result, mon_e[63:0]);
        check("flags", 64'(flags), 64'(mon_e[66:64]));
        check("latency", 64'(cyc - mon_c), 64'd7);
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    end
  endtask

  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] r, input logic [2:0] f);
    issue(a, b);
    exp_q.push_back({f, r});
    cyc_q.push_back(cyc);
    @(negedge clk);
    start = 1'b0;
    op_a  = {$urandom, $urandom};
    op_b  = {$urandom, $urandom};
    wait_done(name);
  endtask

  logic [63:0] rnd_exp;

  initial begin
`ifdef FPU_MUL_RNE_EN
    rnd_exp = 64'h40100002_40100002;
`else
    rnd_exp = 64'h40100001_40100001;
`endif
    reset = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op("basic", 64'h3fc00000_3fc00000, 64'h3fc00000_3fc00000, 64'h40100000_40100000, 3'b000);
    run_op("signs", 64'h3f000000_c0000000, 64'hc0000000_3f000000, 64'hbf800000_bf800000, 3'b000);
    run_op("specials", 64'h7f800000_7f7fffff, 64'h00000000_40000000, 64'h7fc00000_7f800000, 3'b110);
    run_op("underflow", 64'h40000000_00800000, 64'h40400000_00800000, 64'h40c00000_00000000, 3'b001);
    run_op("rounding", 64'h3fc00001_3fc00001, 64'h3fc00001_3fc00001, rnd_exp, 3'b000);
    run_op("nan_negzero", 64'h80000000_7fc00001, 64'h3f800000_3f800000, 64'h80000000_7fc00000, 3'b100);
    run_op("inf_denorm", 64'h7f800000_00000001, 64'hc0000000_3f800000, 64'hff800000_00000000, 3'b000);
    run_op("negnan", 64'hffc00000_3f800000, 64'h3f800000_bf800000, 64'h7fc00000_bf800000, 3'b100);

    // second start at cycle 3 of an operation must be ignored
    issue(64'h3f800000_40000000, 64'h3f800000_40400000);
    exp_q.push_back({3'b000, 64'h3f800000_40c00000});
    cyc_q.push_back(cyc);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op_a  = 64'h3fc00000_3fc00000;
    op_b  = 64'h3fc00000_3fc00000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("dup_start");
    repeat (10) @(negedge clk);

    // reset mid-operation aborts without a done pulse
    issue(64'h40000000_40000000, 64'h40000000_40000000);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_flags", 64'(flags), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);

    run_op("after_reset", 64'h3fc00000_3fc00000, 64'h3fc00000_3fc00000, 64'h40100000_40100000, 3'b000);
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
